// File: rtl/spi_alu_pkg.sv
// Shared types and helpers for the SPI-controlled ALU slave.
package spi_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Frame is op[1:0] followed by A and B.
  function automatic int frame_len(input int width);
    return 2 + 2 * width;
  endfunction

endpackage

// File: rtl/spi_alu_unit.sv
// Combinational ALU with N/Z/C/V flags, evaluated in WIDTH+1 bits.
module spi_alu_unit
  import spi_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0] ext;

  // Operation select; C is "no borrow" for subtraction.
  always_comb begin
    ext = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (op_e'(op))
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        c   = ~ext[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: ext = {1'b0, a & b};
      OP_OR:  ext = {1'b0, a | b};
    endcase
    result = ext[WIDTH-1:0];
    n      = ext[WIDTH-1];
    z      = (ext[WIDTH-1:0] == '0);
  end

endmodule

// File: rtl/spi_alu_slave_sync.sv
// SPI mode-0 ALU slave on a single system clock: synchronized SPI pins,
// frame receive/transmit FSM, registered ALU results and a PWM speed output.
module spi_alu_slave_sync
  import spi_alu_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             SLK,
  input  logic             RST_n,
  input  logic             CS,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_count,
  output logic             speed
);

  localparam int F    = frame_len(WIDTH);
  localparam int BC_W = $clog2(F + 2);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(F);
  localparam logic [BC_W-1:0] BC_MAX  = BC_W'(F + 1);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic cs_q, sclk_q;
  logic cs_s, sclk_s, mosi_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_e state, state_nx;
  logic [BC_W-1:0] bit_cnt, cnt_nx;
  logic [F-1:0]    rx_sr, tx_sr, tx_word;
  logic            fall_pend;
  logic            load_tx, shift_rx, shift_tx, commit, err;

  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [1:0]       alu_op;
  logic             alu_n, alu_z, alu_c, alu_v;
  logic [WIDTH-1:0] pwm_cnt, duty;

  // Synchronizer chains plus one delay stage for edge detection.
  always_ff @(posedge SLK) begin
    if (!RST_n) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_q      <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_q      <= cs_sync[SYNC_STAGES-1];
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;

  // Bit count including an SCLK rise in this cycle, so a coincident CS rise
  // sees the final bit.
  assign cnt_nx = (sclk_rise && bit_cnt != BC_MAX) ? bit_cnt + 1'b1 : bit_cnt;

  // FSM state register.
  always_ff @(posedge SLK) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cs_fall || fall_pend) state_nx = SHIFT;
      SHIFT:   if (cs_rise) state_nx = (cnt_nx == BC_FULL) ? COMMIT : IDLE;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: datapath enables per state.
  always_comb begin
    load_tx  = 1'b0;
    shift_rx = 1'b0;
    shift_tx = 1'b0;
    commit   = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE:   load_tx = 1'b1;
      SHIFT: begin
        shift_rx = sclk_rise;
        shift_tx = sclk_fall;
        err      = cs_rise && (cnt_nx != BC_FULL);
      end
      COMMIT: commit = 1'b1;
      default: ;
    endcase
  end

  // Reply word: previous result and flags, zero padded to the frame length.
  always_comb begin
    tx_word = '0;
    tx_word[F-1 -: WIDTH+4] = {result, N, Z, C, V};
  end

  // Shift registers, bit counter and the deferred CS-fall flag.
  always_ff @(posedge SLK) begin
    if (!RST_n) begin
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      fall_pend <= 1'b0;
    end else begin
      fall_pend <= (state == COMMIT) && cs_fall;
      if (load_tx) begin
        bit_cnt <= '0;
        tx_sr   <= tx_word;
      end else begin
        if (state == SHIFT) bit_cnt <= cnt_nx;
        if (shift_tx)       tx_sr   <= {tx_sr[F-2:0], 1'b0};
      end
      if (shift_rx) rx_sr <= {rx_sr[F-2:0], mosi_s};
    end
  end

  assign MISO   = ~CS & tx_sr[F-1];
  assign alu_op = rx_sr[F-1 -: 2];
  assign alu_a  = rx_sr[2*WIDTH-1 -: WIDTH];
  assign alu_b  = rx_sr[WIDTH-1:0];

  spi_alu_unit #(.WIDTH(WIDTH)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_res),
    .n      (alu_n),
    .z      (alu_z),
    .c      (alu_c),
    .v      (alu_v)
  );

  // Commit register: operands, ALU outputs, status pulses and frame count.
  always_ff @(posedge SLK) begin
    if (!RST_n) begin
      op          <= '0;
      A           <= '0;
      B           <= '0;
      result      <= '0;
      {N, Z, C, V} <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_valid <= commit;
      frame_err   <= err;
      if (commit) begin
        op          <= alu_op;
        A           <= alu_a;
        B           <= alu_b;
        result      <= alu_res;
        {N, Z, C, V} <= {alu_n, alu_z, alu_c, alu_v};
        frame_count <= frame_count + 1'b1;
      end
    end
  end

  // PWM: duty only reloads at counter wrap so a period is never split.
  always_ff @(posedge SLK) begin
    if (!RST_n) begin
      pwm_cnt <= '0;
      duty    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (&pwm_cnt) duty <= result;
    end
  end

  assign speed = (pwm_cnt < duty);

endmodule
